// File: rtl/cfg_loop_seq.sv
// Loop-nest configuration table and odometer sequencer for the npu64 PE array.
// A start latches one table entry and walks its nested loop indices, one tuple per handshake.
module cfg_loop_seq #(
    parameter int unsigned NB_LOOPS  = 5,
    parameter int unsigned LW        = 4,
    parameter int unsigned NB_LAYERS = 8,
    parameter int unsigned OPW       = 3,
    parameter int unsigned KW        = 3,
    parameter int unsigned CW        = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [OPW-1:0]         cfg_addr,
    input  logic [KW-1:0]          cfg_ksi,
    input  logic [CW-1:0]          cfg_ckg,
    input  logic [NB_LOOPS*LW-1:0] cfg_bounds,
    input  logic                   start,
    input  logic [OPW-1:0]         opcode,
    output logic                   busy,
    output logic                   step_valid,
    input  logic                   step_ready,
    output logic [NB_LOOPS*LW-1:0] idx,
    output logic                   first,
    output logic                   last,
    output logic [KW-1:0]          arv_KSI,
    output logic [CW-1:0]          arv_CKG,
    output logic                   done,
    output logic                   start_drop
);

    localparam int unsigned BW = NB_LOOPS * LW;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

    state_e         state_q, state_d;
    logic [BW-1:0]  tbl_bounds_q [NB_LAYERS];
    logic [BW-1:0]  tbl_bounds_d [NB_LAYERS];
    logic [KW-1:0]  tbl_ksi_q    [NB_LAYERS];
    logic [KW-1:0]  tbl_ksi_d    [NB_LAYERS];
    logic [CW-1:0]  tbl_ckg_q    [NB_LAYERS];
    logic [CW-1:0]  tbl_ckg_d    [NB_LAYERS];
    logic [OPW-1:0] op_q, op_d;
    logic [BW-1:0]  bounds_q, bounds_d;
    logic [BW-1:0]  idx_q, idx_d, idx_next;
    logic [KW-1:0]  ksi_q, ksi_d;
    logic [CW-1:0]  ckg_q, ckg_d;
    logic           at_first, at_last, carry;

    always_comb begin
        tbl_bounds_d = tbl_bounds_q;
        tbl_ksi_d    = tbl_ksi_q;
        tbl_ckg_d    = tbl_ckg_q;
        if (cfg_we) begin
            tbl_bounds_d[cfg_addr] = cfg_bounds;
            tbl_ksi_d[cfg_addr]    = cfg_ksi;
            tbl_ckg_d[cfg_addr]    = cfg_ckg;
        end
    end

    // Ripple-carry odometer: each field wraps independently so a bound of all-ones never spills over.
    always_comb begin
        idx_next = idx_q;
        carry    = 1'b1;
        at_first = 1'b1;
        at_last  = 1'b1;
        for (int unsigned i = 0; i < NB_LOOPS; i++) begin
            if (idx_q[i*LW +: LW] != '0) at_first = 1'b0;
            if (idx_q[i*LW +: LW] != bounds_q[i*LW +: LW]) at_last = 1'b0;
            if (carry) begin
                if (idx_q[i*LW +: LW] == bounds_q[i*LW +: LW]) begin
                    idx_next[i*LW +: LW] = '0;
                end else begin
                    idx_next[i*LW +: LW] = idx_q[i*LW +: LW] + 1'b1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bounds_d   = bounds_q;
        idx_d      = idx_q;
        ksi_d      = ksi_q;
        ckg_d      = ckg_q;
        busy       = 1'b1;
        step_valid = 1'b0;
        done       = 1'b0;
        start_drop = start;
        case (state_q)
            S_IDLE: begin
                busy       = 1'b0;
                start_drop = 1'b0;
                if (start) begin
                    op_d    = opcode;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                bounds_d = tbl_bounds_q[op_q];
                ksi_d    = tbl_ksi_q[op_q];
                ckg_d    = tbl_ckg_q[op_q];
                idx_d    = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                step_valid = 1'b1;
                if (step_ready) begin
                    if (at_last) state_d = S_DONE;
                    else         idx_d   = idx_next;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        first = step_valid & at_first;
        last  = step_valid & at_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            bounds_q <= '0;
            idx_q    <= '0;
            ksi_q    <= '0;
            ckg_q    <= '0;
            for (int unsigned i = 0; i < NB_LAYERS; i++) begin
                tbl_bounds_q[i] <= '0;
                tbl_ksi_q[i]    <= '0;
                tbl_ckg_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            bounds_q     <= bounds_d;
            idx_q        <= idx_d;
            ksi_q        <= ksi_d;
            ckg_q        <= ckg_d;
            tbl_bounds_q <= tbl_bounds_d;
            tbl_ksi_q    <= tbl_ksi_d;
            tbl_ckg_q    <= tbl_ckg_d;
        end
    end

    assign idx     = idx_q;
    assign arv_KSI = ksi_q;
    assign arv_CKG = ckg_q;

endmodule

// File: tb/tb_cfg_loop_seq.sv
// Self-checking bench for cfg_loop_seq: directed layers plus randomized tables and ready patterns,
// checked against a mixed-radix model of the loop nest.
module tb_cfg_loop_seq;

    logic        clk, rst_n, cfg_we, start, step_ready;
    logic [2:0]  cfg_addr, cfg_ksi, cfg_ckg, opcode;
    logic [19:0] cfg_bounds, idx;
    logic        busy, step_valid, first, last, done, start_drop;
    logic [2:0]  arv_KSI, arv_CKG;

    int n_cmp = 0;
    int n_fail = 0;

    logic [19:0] m_bnd [8];
    logic [2:0]  m_ksi [8];
    logic [2:0]  m_ckg [8];

    cfg_loop_seq #(
        .NB_LOOPS(5), .LW(4), .NB_LAYERS(8), .OPW(3), .KW(3), .CW(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_ksi(cfg_ksi), .cfg_ckg(cfg_ckg), .cfg_bounds(cfg_bounds),
        .start(start), .opcode(opcode), .busy(busy), .step_valid(step_valid),
        .step_ready(step_ready), .idx(idx), .first(first), .last(last),
        .arv_KSI(arv_KSI), .arv_CKG(arv_CKG), .done(done), .start_drop(start_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Step k of the nest, decomposed as a mixed-radix number with radix (bound+1) per level.
    function automatic logic [19:0] exp_idx(input logic [19:0] b, input int unsigned k);
        int unsigned r = k;
        int unsigned rad;
        logic [19:0] v = '0;
        for (int i = 0; i < 5; i++) begin
            rad = 32'(b[i*4 +: 4]) + 1;
            v[i*4 +: 4] = 4'(r % rad);
            r = r / rad;
        end
        return v;
    endfunction

    function automatic int unsigned nsteps(input logic [19:0] b);
        int unsigned p = 1;
        for (int i = 0; i < 5; i++) p = p * (32'(b[i*4 +: 4]) + 1);
        return p;
    endfunction

    task automatic write_entry(input logic [2:0] a, input logic [19:0] b,
                               input logic [2:0] k, input logic [2:0] c);
        cfg_we = 1'b1; cfg_addr = a; cfg_bounds = b; cfg_ksi = k; cfg_ckg = c;
        m_bnd[a] = b; m_ksi[a] = k; m_ckg[a] = c;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m_bnd[i] = '0; m_ksi[i] = '0; m_ckg[i] = '0;
        end
    endtask

    // mode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready
    task automatic run_layer(input logic [2:0] op, input int mode, input bit inj,
                             input bit mid_wr, input bit co_wr, input logic [19:0] co_b);
        logic [19:0] eb, prev_idx;
        logic [2:0]  ek, ec;
        int unsigned n, k, cyc, drops;
        bit got_done, hs, stalled, run_drop, done_drop;
        start = 1'b1;
        opcode = op;
        if (co_wr) begin
            cfg_we = 1'b1; cfg_addr = op; cfg_bounds = co_b; cfg_ksi = 3'd5; cfg_ckg = 3'd3;
            m_bnd[op] = co_b; m_ksi[op] = 3'd5; m_ckg[op] = 3'd3;
        end
        eb = m_bnd[op]; ek = m_ksi[op]; ec = m_ckg[op];
        n = nsteps(eb);
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_no_drop", 32'(start_drop), 0);
        tick();
        start = 1'b0; cfg_we = 1'b0;
        #1;
        chk("load_busy", 32'(busy), 1);
        chk("load_no_valid", 32'(step_valid), 0);
        tick();
        cyc = 2; k = 0; drops = 0; got_done = 0; stalled = 0; prev_idx = '0;
        run_drop = 0; done_drop = 0;
        while (!got_done && cyc < 40 + 8 * n) begin
            case (mode)
                0: step_ready = 1'b1;
                1: step_ready = ((cyc - 2) % 4 == 0) || ((cyc - 2) % 4 == 3);
                default: step_ready = 1'($urandom_range(0, 1));
            endcase
            if (inj && !run_drop && k == 2) begin start = 1'b1; run_drop = 1; end
            if (inj && !done_drop && k == n) begin start = 1'b1; done_drop = 1; end
            if (mid_wr && cyc == 3) begin
                cfg_we = 1'b1; cfg_addr = op; cfg_bounds = '0; cfg_ksi = '0; cfg_ckg = '0;
                m_bnd[op] = '0; m_ksi[op] = '0; m_ckg[op] = '0;
            end
            #1;
            chk("start_drop", 32'(start_drop), 32'(start));
            if (start_drop) drops++;
            if (done) begin
                got_done = 1;
                chk("done_steps", k, n);
                chk("done_no_valid", 32'(step_valid), 0);
                chk("done_busy", 32'(busy), 1);
                chk("done_idx_hold", 32'(idx), 32'(exp_idx(eb, n - 1)));
                chk("done_ksi", 32'(arv_KSI), 32'(ek));
                chk("done_ckg", 32'(arv_CKG), 32'(ec));
                if (mode == 0) chk("latency", cyc, n + 2);
            end else begin
                chk("run_valid", 32'(step_valid), 1);
                chk("idx", 32'(idx), 32'(exp_idx(eb, k)));
                chk("first", 32'(first), 32'(k == 0));
                chk("last", 32'(last), 32'(k == n - 1));
                if (stalled) chk("stall_hold", 32'(idx), 32'(prev_idx));
                if (cyc == 2) begin
                    chk("run_ksi", 32'(arv_KSI), 32'(ek));
                    chk("run_ckg", 32'(arv_CKG), 32'(ec));
                end
            end
            hs = !got_done && (k < n) && step_ready;
            stalled = !got_done && (k < n) && !step_ready;
            prev_idx = idx;
            tick();
            start = 1'b0; cfg_we = 1'b0;
            if (hs) k++;
            cyc++;
        end
        chk("done_seen", 32'(got_done), 1);
        #1;
        chk("post_idle", 32'(busy), 0);
        chk("single_done", 32'(done), 0);
        if (inj) chk("drop_count", drops, 2);
    endtask

    initial begin
        logic [19:0] rb;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_ksi = '0; cfg_ckg = '0;
        cfg_bounds = '0; start = 1'b0; opcode = '0; step_ready = 1'b0;
        clear_model();
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(step_valid), 0);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_ksi", 32'(arv_KSI), 0);
        chk("rst_ckg", 32'(arv_CKG), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_first_last", 32'({first, last}), 0);
        #9 rst_n = 1'b1;
        tick();

        write_entry(3'd3, 20'h00201, 3'd4, 3'd7);
        run_layer(3'd3, 0, 0, 0, 0, '0);
        run_layer(3'd3, 1, 0, 0, 0, '0);
        run_layer(3'd0, 0, 0, 0, 0, '0);
        run_layer(3'd3, 0, 1, 0, 0, '0);
        run_layer(3'd3, 0, 0, 1, 0, '0);
        run_layer(3'd3, 0, 0, 0, 0, '0);
        run_layer(3'd3, 0, 0, 0, 1, 20'h00201);

        for (int r = 0; r < 6; r++) begin
            rb = '0;
            for (int i = 0; i < 5; i++) rb[i*4 +: 4] = 4'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) rb[$urandom_range(0, 4)*4 +: 4] = 4'hF;
            write_entry(3'($urandom_range(0, 7)), rb, 3'($urandom_range(0, 7)),
                        3'($urandom_range(0, 7)));
            run_layer(cfg_addr, $urandom_range(0, 2), 0, 0, 0, '0);
        end

        write_entry(3'd3, 20'h00201, 3'd4, 3'd7);
        step_ready = 1'b1;
        start = 1'b1; opcode = 3'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk("pre_reset_idx", 32'(idx), 32'(exp_idx(20'h00201, 2)));
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_valid", 32'(step_valid), 0);
        chk("async_idx", 32'(idx), 0);
        chk("async_arv", 32'({arv_KSI, arv_CKG}), 0);
        chk("async_done", 32'(done), 0);
        clear_model();
        tick();
        chk("reset_hold_done", 32'(done), 0);
        #1 rst_n = 1'b1;
        tick();
        #1;
        chk("after_reset_done", 32'(done), 0);
        chk("after_reset_busy", 32'(busy), 0);
        run_layer(3'd3, 0, 0, 0, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
